// File: rtl/fp_pkg.sv
// Shared float helpers: field constants, flag bit positions and operand classes.
package fp_pkg;

  localparam int FLAG_W         = 3;
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all-ones, only the fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'(1) << exp_w) - 64'(1)) << man_w) | (64'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result streaming bundle for the multiplier; master drives operands, slave is the block.
interface fp_mult_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/sig_mult.sv
// Unsigned significand multiplier, combinational, full-width product; the DSP-mapping point.
module sig_mult #(
  parameter int N = 11
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);
  assign p = (2*N)'(x) * (2*N)'(y);
endmodule

// File: rtl/fp_mult_pipe.sv
// IEEE-style float multiplier, RNE, flush-to-zero; 3-cycle latency, 1/cycle.
// Single global stall: every stage holds while the output is valid and not taken.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic          clk,
  input logic          rst_n,
  fp_mult_pipe_if.slave bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int P      = 2 * SIG_W;
  localparam int XW     = EXP_W + 2;
  localparam int BIAS   = fp_bias(EXP_W);
  localparam int EXP_MX = fp_exp_max(EXP_W);
  localparam logic [63:0]          QNAN64   = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN     = QNAN64[W-1:0];
  localparam logic signed [XW-1:0] EXP_MX_X = XW'(EXP_MX);

  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // S1: unpack and classify
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  fp_class_e        cls_c;
  logic [P-1:0]     prod_c;
  logic [XW-1:0]    exp_c;

  assign ea     = bus.a[W-2 -: EXP_W];
  assign eb     = bus.b[W-2 -: EXP_W];
  assign fa     = bus.a[MAN_W-1:0];
  assign fb     = bus.b[MAN_W-1:0];
  assign a_nan  = (ea == EXP_W'(EXP_MX)) && (fa != '0);
  assign b_nan  = (eb == EXP_W'(EXP_MX)) && (fb != '0);
  assign a_inf  = (ea == EXP_W'(EXP_MX)) && (fa == '0);
  assign b_inf  = (eb == EXP_W'(EXP_MX)) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign exp_c  = XW'(ea) + XW'(eb) - XW'(BIAS);

  always_comb begin
    cls_c = NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) cls_c = NAN;
    else if (a_inf || b_inf)                                       cls_c = INF;
    else if (a_zero || b_zero)                                     cls_c = ZERO;
  end

  sig_mult #(.N(SIG_W)) u_sig_mult (
    .x ({1'b1, fa}),
    .y ({1'b1, fb}),
    .p (prod_c)
  );

  logic                    s1_vld, s1_sign;
  fp_class_e               s1_cls;
  logic [P-1:0]            s1_prod;
  logic signed [XW-1:0]    s1_exp;

  // S2: normalise so the leading one sits at bit P-1, then split off G/R/S
  logic [P-1:0]  norm_c;
  logic [XW-1:0] exp2_c;
  assign norm_c = s1_prod[P-1] ? s1_prod : {s1_prod[P-2:0], 1'b0};
  assign exp2_c = s1_exp + XW'(s1_prod[P-1]);

  logic                 s2_vld, s2_sign, s2_g, s2_r, s2_s;
  fp_class_e            s2_cls;
  logic [MAN_W-1:0]     s2_frac;
  logic signed [XW-1:0] s2_exp;

  // S3: round to nearest even; a carry out of the fraction bumps the exponent
  logic                 up_c;
  logic [MAN_W:0]       rsum_c;
  logic signed [XW-1:0] exp3_c;
  logic [W-1:0]         res_dat;
  logic [FLAG_W-1:0]    res_flg;

  assign up_c   = s2_g && (s2_r || s2_s || s2_frac[0]);
  assign rsum_c = {1'b0, s2_frac} + (MAN_W+1)'(up_c);
  assign exp3_c = s2_exp + XW'(rsum_c[MAN_W]);

  always_comb begin
    res_dat = {s2_sign, exp3_c[EXP_W-1:0], rsum_c[MAN_W-1:0]};
    res_flg = '0;
    case (s2_cls)
      NAN: begin
        res_dat               = QNAN;
        res_flg[FLAG_INVALID] = 1'b1;
      end
      INF:  res_dat = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: res_dat = {s2_sign, {(W-1){1'b0}}};
      default: begin
        if (!exp3_c[XW-1] && exp3_c >= EXP_MX_X) begin
          res_dat                = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          res_flg[FLAG_OVERFLOW] = 1'b1;
        end else if (exp3_c[XW-1] || exp3_c == XW'(0)) begin
          res_dat                 = {s2_sign, {(W-1){1'b0}}};
          res_flg[FLAG_UNDERFLOW] = 1'b1;
        end
      end
    endcase
  end

  logic              out_vld;
  logic [W-1:0]      out_dat;
  logic [FLAG_W-1:0] out_flg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_cls  <= ZERO;
      s1_prod <= '0;
      s1_exp  <= '0;
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_cls  <= ZERO;
      s2_frac <= '0;
      s2_exp  <= '0;
      s2_g    <= 1'b0;
      s2_r    <= 1'b0;
      s2_s    <= 1'b0;
      out_vld <= 1'b0;
      out_dat <= '0;
      out_flg <= '0;
    end else if (en) begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= bus.a[W-1] ^ bus.b[W-1];
        s1_cls  <= cls_c;
        s1_prod <= prod_c;
        s1_exp  <= exp_c;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sign <= s1_sign;
        s2_cls  <= s1_cls;
        s2_exp  <= exp2_c;
        s2_frac <= norm_c[P-2 -: MAN_W];
        s2_g    <= norm_c[P-2-MAN_W];
        s2_r    <= norm_c[P-3-MAN_W];
        s2_s    <= |norm_c[P-4-MAN_W:0];
      end
      out_vld <= s2_vld;
      if (s2_vld) begin
        out_dat <= res_dat;
        out_flg <= res_flg;
      end
    end
  end

  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_dat;
  assign bus.out_flags = out_flg;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: vector table through a scoreboard, plus stall and reset sequences.
module tb_fp_mult_pipe;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] dat;
    logic [2:0]  flg;
  } vec_t;

  typedef struct packed {
    logic [15:0] dat;
    logic [2:0]  flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) bus ();
  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  exp_t sb[$];
  int   out_cyc[$];
  logic        stalled_prev = 1'b0;
  logic [15:0] held_dat;
  logic [2:0]  held_flg;
  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // One cycle: drive at negedge, then compare what transfers at the next posedge.
  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input exp_t e, input logic ordy, output logic acc);
    exp_t x;
    @(negedge clk);
    cyc++;
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.out_ready = ordy;
    #1;
    if (stalled_prev) begin
      check("hold_data", 32'(bus.out_data), 32'(held_dat));
      check("hold_flags", 32'(bus.out_flags), 32'(held_flg));
    end
    stalled_prev = bus.out_valid && !bus.out_ready;
    if (stalled_prev) begin
      held_dat = bus.out_data;
      held_flg = bus.out_flags;
      check("in_ready_stall", 32'(bus.in_ready), 32'd0);
    end
    if (bus.out_valid && bus.out_ready) begin
      out_cyc.push_back(cyc);
      if (sb.size() == 0) check("extra_output", 32'd1, 32'd0);
      else begin
        x = sb.pop_front();
        check("data", 32'(bus.out_data), 32'(x.dat));
        check("flags", 32'(bus.out_flags), 32'(x.flg));
      end
    end
    acc = iv && bus.in_ready;
    if (acc) sb.push_back(e);
  endtask

  task automatic send(input vec_t v, inout int p, input logic toggle);
    logic acc;
    exp_t e;
    e.dat = v.dat;
    e.flg = v.flg;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      step(1'b1, v.a, v.b, e, toggle ? ((p % 3) == 0) : 1'b1, acc);
      p++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(inout int p, input logic toggle);
    logic acc;
    for (int t = 0; t < 60 && sb.size() > 0; t++) begin
      step(1'b0, 16'h0, 16'h0, '0, toggle ? ((p % 3) == 0) : 1'b1, acc);
      p++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    int acc_cyc;
    int n0;
    int seen;
    logic acc;
    exp_t e;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    vt[0]  = '{16'h3E00, 16'h3E00, 16'h4080, 3'b000};
    vt[1]  = '{16'h3C00, 16'h4000, 16'h4000, 3'b000};
    vt[2]  = '{16'h3C01, 16'h3E00, 16'h3E02, 3'b000};
    vt[3]  = '{16'h3C01, 16'h3C01, 16'h3C02, 3'b000};
    vt[4]  = '{16'h7BFF, 16'h4000, 16'h7C00, 3'b010};
    vt[5]  = '{16'hFBFF, 16'h4000, 16'hFC00, 3'b010};
    vt[6]  = '{16'h7C00, 16'h0000, 16'h7E00, 3'b100};
    vt[7]  = '{16'h7E01, 16'h3C00, 16'h7E00, 3'b100};
    vt[8]  = '{16'h8000, 16'h4000, 16'h8000, 3'b000};
    vt[9]  = '{16'h0400, 16'h3800, 16'h0000, 3'b001};
    vt[10] = '{16'h0001, 16'h3C00, 16'h0000, 3'b000};
    vt[11] = '{16'hC000, 16'h3E00, 16'hC200, 3'b000};

    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    check("reset_out_flags", 32'(bus.out_flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Back-to-back table run with the output always taken
    p = 0;
    acc_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      send(vt[i], p, 1'b0);
      if (i == 0) acc_cyc = cyc;
    end
    drain(p, 1'b0);
    check("output_count", 32'(out_cyc.size()), 32'd12);
    if (out_cyc.size() >= 2) begin
      check("latency", 32'(out_cyc[0] - acc_cyc), 32'd3);
      check("back_to_back", 32'(out_cyc[1] - out_cyc[0]), 32'd1);
    end

    // Stream under a 1,0,0 out_ready pattern
    p = 0;
    n0 = out_cyc.size();
    for (int i = 0; i < 5; i++) send(vt[i + 2], p, 1'b1);
    drain(p, 1'b1);
    check("stream_count", 32'(out_cyc.size() - n0), 32'd5);

    // Reset with three products in flight
    for (int i = 0; i < 3; i++) send(vt[i], p, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset_out_data", 32'(bus.out_data), 32'd0);
    sb.delete();
    stalled_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("no_output_after_reset", 32'(seen), 32'd0);
    check("in_ready_after_midreset", 32'(bus.in_ready), 32'd1);

    // One product after recovery to show the pipe still works
    e.dat = 16'h4080;
    e.flg = 3'b000;
    step(1'b1, 16'h3E00, 16'h3E00, e, 1'b1, acc);
    check("post_reset_accept", 32'(acc), 32'd1);
    drain(p, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
